// File: rtl/ahb_timer_pkg.sv
// Shared constants and helpers for the AHB-lite timer: register offsets,
// CTRL bit positions, byte-strobe decode and byte-lane merge.
package ahb_timer_pkg;

  localparam logic [4:0] TMR_CTRL_OFS   = 5'h00;
  localparam logic [4:0] TMR_LOAD_OFS   = 5'h04;
  localparam logic [4:0] TMR_VALUE_OFS  = 5'h08;
  localparam logic [4:0] TMR_PRESC_OFS  = 5'h0C;
  localparam logic [4:0] TMR_STATUS_OFS = 5'h10;
  localparam logic [4:0] TMR_CMP_OFS    = 5'h14;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_IE_BIT      = 1;
  localparam int unsigned CTRL_ONESHOT_BIT = 2;
  localparam int unsigned CTRL_W           = 3;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;

  // Byte lanes touched by a transfer of the given size at the given address.
  function automatic logic [3:0] byte_strobe(input logic [2:0] hsize,
                                             input logic [1:0] addr);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_timer_core.sv
// Prescaler, down-counter and interrupt flag of the timer; register values
// and write pulses come from the bus-side register file.
module ahb_timer_core
  import ahb_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [CNT_W-1:0]   load_i,
  input  logic               value_wr_i,
  input  logic [CNT_W-1:0]   value_wdata_i,
  input  logic               if_clr_i,
  output logic [CNT_W-1:0]   value_o,
  output logic               if_o,
  output logic               tick_c_o,
  output logic               underflow_c_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   value_q, value_d;
  logic               if_q, if_d;
  logic               tick;
  logic               underflow;

  // A bus write to VALUE swallows a coincident tick, so no underflow either.
  always_comb begin
    pcnt_d    = pcnt_q;
    value_d   = value_q;
    if_d      = if_q;
    tick      = en_i && (pcnt_q == presc_i);
    underflow = tick && !value_wr_i && (value_q == '0);

    if (!en_i || tick) pcnt_d = '0;
    else               pcnt_d = pcnt_q + PRESC_W'(1);

    if (value_wr_i)  value_d = value_wdata_i;
    else if (tick)   value_d = (value_q == '0) ? load_i : value_q - CNT_W'(1);

    if (underflow)     if_d = 1'b1;
    else if (if_clr_i) if_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q  <= '0;
      value_q <= '1;
      if_q    <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      value_q <= value_d;
      if_q    <= if_d;
    end
  end

  assign value_o       = value_q;
  assign if_o          = if_q;
  assign tick_c_o      = tick;
  assign underflow_c_o = underflow;

endmodule

// File: rtl/ahb_timer.sv
// AHB-lite timer slave: bus interface and register file around ahb_timer_core.
// Define TIMER_PWM_EN to add the CMP register and the PWM_OUT port.
module ahb_timer
  import ahb_timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        INT_REQ
`ifdef TIMER_PWM_EN
  ,
  output logic        PWM_OUT
`endif
);

  logic               accept;
  logic               wr_q, rd_q;
  logic [4:0]         addr_q;
  logic [3:0]         strb_q;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               value_wr;
  logic [CNT_W-1:0]   value_wdata;
  logic               if_clr;
  logic [CNT_W-1:0]   value;
  logic               irq_flag;
  logic               tick;
  logic               underflow;
  logic [31:0]        rdata;
  logic               unused_bits;
`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic               pwm_q;
`endif

  assign accept = HSEL && HREADY && HTRANS[1];

  // Address phase capture; reset drops any transfer already in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      strb_q <= '0;
    end else begin
      wr_q <= accept && HWRITE;
      rd_q <= accept && !HWRITE;
      if (accept) begin
        addr_q <= {HADDR[4:2], 2'b00};
        strb_q <= byte_strobe(HSIZE, HADDR[1:0]);
      end
    end
  end

  // Data phase write decode; a one-shot underflow overrides the EN bit.
  always_comb begin
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    presc_d     = presc_q;
    value_wr    = 1'b0;
    if_clr      = 1'b0;
    value_wdata = CNT_W'(byte_merge(32'(value), HWDATA, strb_q));
`ifdef TIMER_PWM_EN
    cmp_d       = cmp_q;
`endif
    if (wr_q) begin
      case (addr_q)
        TMR_CTRL_OFS:   ctrl_d   = CTRL_W'(byte_merge(32'(ctrl_q), HWDATA, strb_q));
        TMR_LOAD_OFS:   load_d   = CNT_W'(byte_merge(32'(load_q), HWDATA, strb_q));
        TMR_VALUE_OFS:  value_wr = 1'b1;
        TMR_PRESC_OFS:  presc_d  = PRESC_W'(byte_merge(32'(presc_q), HWDATA, strb_q));
        TMR_STATUS_OFS: if_clr   = strb_q[0] && HWDATA[0];
`ifdef TIMER_PWM_EN
        TMR_CMP_OFS:    cmp_d    = CNT_W'(byte_merge(32'(cmp_q), HWDATA, strb_q));
`endif
        default: ;
      endcase
    end
    if (underflow && ctrl_q[CTRL_ONESHOT_BIT]) ctrl_d[CTRL_EN_BIT] = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_q  <= '0;
      load_q  <= '1;
      presc_q <= '0;
`ifdef TIMER_PWM_EN
      cmp_q   <= '0;
      pwm_q   <= 1'b0;
`endif
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      presc_q <= presc_d;
`ifdef TIMER_PWM_EN
      cmp_q   <= cmp_d;
      pwm_q   <= ctrl_q[CTRL_EN_BIT] && (value < cmp_q);
`endif
    end
  end

  ahb_timer_core #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_core (
    .clk_i         (HCLK),
    .rst_i         (HRESET),
    .en_i          (ctrl_q[CTRL_EN_BIT]),
    .presc_i       (presc_q),
    .load_i        (load_q),
    .value_wr_i    (value_wr),
    .value_wdata_i (value_wdata),
    .if_clr_i      (if_clr),
    .value_o       (value),
    .if_o          (irq_flag),
    .tick_c_o      (tick),
    .underflow_c_o (underflow)
  );

  // Read mux over the latched address; reads have no side effects.
  always_comb begin
    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        TMR_CTRL_OFS:   rdata = 32'(ctrl_q);
        TMR_LOAD_OFS:   rdata = 32'(load_q);
        TMR_VALUE_OFS:  rdata = 32'(value);
        TMR_PRESC_OFS:  rdata = 32'(presc_q);
        TMR_STATUS_OFS: rdata = 32'(irq_flag);
`ifdef TIMER_PWM_EN
        TMR_CMP_OFS:    rdata = 32'(cmp_q);
`endif
        default:        rdata = '0;
      endcase
    end
  end

  assign HRDATA      = rdata;
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign INT_REQ     = irq_flag && ctrl_q[CTRL_IE_BIT];
  assign unused_bits = ^{HADDR[15:5], HTRANS[0], tick};
`ifdef TIMER_PWM_EN
  assign PWM_OUT     = pwm_q;
`endif

endmodule

// File: tb/tb_ahb_timer.sv
// Randomised bench for ahb_timer: a behavioural timer model predicts reads,
// INT_REQ and PWM_OUT; a monitor compares them against the DUT every cycle.
module tb_ahb_timer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        INT_REQ;
`ifdef TIMER_PWM_EN
  logic        PWM_OUT;
`endif

  always #5 HCLK = ~HCLK;

  ahb_timer dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .INT_REQ   (INT_REQ)
`ifdef TIMER_PWM_EN
    ,
    .PWM_OUT   (PWM_OUT)
`endif
  );

  // Reference state, kept as plain numbers
  logic [31:0] m_ctrl, m_load, m_val, m_presc, m_cmp, m_pc;
  logic        m_if, m_pwm;
  bit          p_wr;
  logic [4:0]  p_addr;
  logic [31:0] p_mask;
  bit          m_rd_dph;
  bit          m_live = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] nxt_wdata;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] size_mask(input logic [2:0] sz, input logic [1:0] a);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (sz == 3'd0)      m = 32'h0000_00FF << (8 * int'(a));
    else if (sz == 3'd1) m = 32'h0000_FFFF << (16 * int'(a[1]));
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return m_ctrl;
      3'd1: return m_load;
      3'd2: return m_val;
      3'd3: return m_presc;
      3'd4: return {31'd0, m_if};
`ifdef TIMER_PWM_EN
      3'd5: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer as the register map describes it.
  task automatic model_edge();
    logic [31:0] wd, nw;
    bit          tick, vw, uf, oneshot;
    if (HRESET) begin
      m_ctrl = 0; m_load = 32'hFFFF_FFFF; m_val = 32'hFFFF_FFFF;
      m_presc = 0; m_cmp = 0; m_pc = 0; m_if = 0; m_pwm = 0;
      p_wr = 0; m_rd_dph = 0;
      return;
    end
    wd      = HWDATA;
    oneshot = m_ctrl[2];
    tick    = m_ctrl[0] && (m_pc == m_presc);
    vw      = p_wr && (p_addr[4:2] == 3'd2);
    uf      = tick && !vw && (m_val == 0);
`ifdef TIMER_PWM_EN
    m_pwm   = m_ctrl[0] && (m_val < m_cmp);
`endif
    m_pc    = (!m_ctrl[0] || tick) ? 32'd0 : ((m_pc + 1) & 32'hFFFF);
    nw      = 0;
    if (vw)        m_val = (m_val & ~p_mask) | (wd & p_mask);
    else if (tick) m_val = (m_val == 0) ? m_load : m_val - 1;
    if (p_wr) begin
      case (p_addr[4:2])
        3'd0: m_ctrl  = ((m_ctrl & ~p_mask) | (wd & p_mask)) & 32'h7;
        3'd1: m_load  = (m_load & ~p_mask) | (wd & p_mask);
        3'd3: m_presc = ((m_presc & ~p_mask) | (wd & p_mask)) & 32'hFFFF;
        3'd4: if (p_mask[0] && wd[0]) m_if = 0;
`ifdef TIMER_PWM_EN
        3'd5: m_cmp   = (m_cmp & ~p_mask) | (wd & p_mask);
`endif
        default: nw = 0;
      endcase
    end
    if (uf) begin
      m_if = 1;
      if (oneshot) m_ctrl[0] = 0;
    end
    p_wr = 0;
    m_rd_dph = 0;
    if (HSEL && HREADY && HTRANS[1]) begin
      if (HWRITE) begin
        p_wr = 1; p_addr = HADDR[4:0]; p_mask = size_mask(HSIZE, HADDR[1:0]);
      end else begin
        exp_q.push_back(m_read(HADDR[4:0]));
        m_rd_dph = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge HCLK);
    model_edge();
    m_live = 1'b1;
  end

  // Monitor: every mid-cycle compare status outputs and any read data phase.
  initial forever begin
    @(negedge HCLK);
    if (m_live) begin
      check("int_req", 32'(INT_REQ), 32'(m_if && m_ctrl[1]));
      check("hreadyout", 32'(HREADYOUT), 32'd1);
      check("hresp", 32'(HRESP), 32'd0);
`ifdef TIMER_PWM_EN
      check("pwm_out", 32'(PWM_OUT), 32'(m_pwm));
`endif
      if (m_rd_dph) begin
        if (exp_q.size() == 0) check("scoreboard_underrun", 32'd1, 32'd0);
        else check("hrdata", HRDATA, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [4:0] a, input logic [2:0] sz, input logic [31:0] d);
    @(negedge HCLK);
    HWDATA    = nxt_wdata;
    HSEL      = sel;
    HTRANS    = tr;
    HWRITE    = wr;
    HADDR     = {11'($urandom), a};
    HSIZE     = sz;
    nxt_wdata = (sel && tr[1] && wr) ? d : $urandom;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [2:0] sz = 3'd2);
    drive(1'b1, 2'b10, 1'b1, a, sz, d);
  endtask

  task automatic rd(input logic [4:0] a);
    drive(1'b1, 2'b10, 1'b0, a, 3'd2, 32'd0);
  endtask

  task automatic idle(input int n = 1);
    for (int k = 0; k < n; k++)
      drive(1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom), 5'($urandom), 3'd2, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge HCLK);
    HRESET = 1'b1;
    HWDATA = nxt_wdata;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    repeat (n) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    logic [4:0]  a;
    logic [2:0]  sz;
    logic [31:0] d;
    int unsigned op;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2;
    HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; nxt_wdata = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    // reset values and unmapped offsets
    for (int r = 0; r < 8; r++) rd(5'(r * 4));
    idle(2);

    // periodic interrupt, then W1C
    wr(5'h04, 32'd4); wr(5'h08, 32'd4); wr(5'h0C, 32'd0); wr(5'h00, 32'h3);
    repeat (10) rd(5'h08);
    wr(5'h00, 32'h2);
    rd(5'h10);
    wr(5'h10, 32'h1);
    idle(2);
    rd(5'h10);

    // prescaler with one-shot
    wr(5'h0C, 32'd2); wr(5'h04, 32'd7); wr(5'h08, 32'd1); wr(5'h00, 32'h5);
    for (int r = 0; r < 12; r++) begin rd(5'h08); rd(5'h00); end
    wr(5'h10, 32'h1);

    // collisions: every cycle ticks with PRESC=0
    wr(5'h0C, 32'd0); wr(5'h04, 32'd3); wr(5'h00, 32'h3);
    wr(5'h08, 32'h10); rd(5'h08);
    wr(5'h04, 32'd0); wr(5'h08, 32'd0);
    wr(5'h10, 32'h1); wr(5'h10, 32'h1); rd(5'h10);
    wr(5'h00, 32'h7); wr(5'h00, 32'h2); rd(5'h00); rd(5'h10);

    // sub-word access and unmapped reads
    wr(5'h00, 32'h0); wr(5'h04, 32'h0);
    wr(5'h05, {4{8'hAB}}, 3'd0); rd(5'h04);
    wr(5'h0E, 32'h1234_5678, 3'd1); rd(5'h0C);
    wr(5'h0C, 32'hFFFF_9ABC); rd(5'h0C);
    rd(5'h18); rd(5'h1C);
    drive(1'b0, 2'b10, 1'b1, 5'h04, 3'd2, 32'h5555_5555); rd(5'h04);

`ifdef TIMER_PWM_EN
    wr(5'h04, 32'd9); wr(5'h14, 32'd3); wr(5'h0C, 32'd0); wr(5'h08, 32'd9); wr(5'h00, 32'h1);
    idle(30);
`else
    wr(5'h14, 32'hFFFF_FFFF); rd(5'h14);
`endif

    // reset mid-count with a write in its data phase
    wr(5'h0C, 32'd0); wr(5'h00, 32'h3);
    idle(3);
    wr(5'h08, 32'h55);
    do_reset(2);
    rd(5'h08); rd(5'h00); rd(5'h04);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 199);
      sz = 3'($urandom_range(0, 2));
      a  = {3'($urandom_range(0, 7)), 2'b00};
      if (sz == 3'd0)      a[1:0] = 2'($urandom);
      else if (sz == 3'd1) a[1]   = 1'($urandom);
      if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 12)) << (8 * int'(a[1:0]));
      else                           d = $urandom;
      if (op < 1)        do_reset(1);
      else if (op < 100) wr(a, d, sz);
      else if (op < 170) rd(a);
      else if (op < 186) idle();
      else               drive(1'b0, 2'b10, 1'($urandom), a, sz, d);
    end

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
